// File: rtl/pci_target_dec_fsm.sv
// rtl/pci_target_dec_fsm.sv - PCI target address-phase decoder and transaction sequencer

module pci_target_dec_fsm #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        PHY_CLK33_I,
   input  logic        PHY_RST_I,
   input  logic        PCI_FRAMEn_I,
   input  logic        PCI_IRDYn_I,
   input  logic        PCI_IDSEL_I,
   input  logic [31:0] PCI_AD_I,
   input  logic [3:0]  PCI_CBEn_I,
   input  logic [31:0] CFG_REG_0x04_I,
   input  logic [31:0] CFG_REG_0x10_I,
   input  logic [31:0] CFG_REG_0x11_I,
   output logic [21:0] PCI_ADD_O,
   output logic        CFG_WR_O,
   output logic        DEFSM_ADD2CFG_O,
   input  logic        DEFSM_CFG_END_I,
   output logic        MEM_SEL_O,
   output logic        MEM_BAR_O,
   output logic        MEM_WR_O,
   input  logic        DEFSM_MEM_END_I,
   output logic        CFG_STATE_ABORT_O,
   output logic        DEFSM_BUSY_O,
   output logic [2:0]  DEFSM_STATE_O
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CFG    = 3'd1,
      ST_MEM    = 3'd2,
      ST_IGNORE = 3'd3,
      ST_TURN   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic            frame_prev_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [21:0]     add_q, add_d;
   logic            cfg_wr_q, cfg_wr_d;
   logic            add2cfg_q, add2cfg_d;
   logic            mem_sel_q, mem_sel_d;
   logic            mem_bar_q, mem_bar_d;
   logic            mem_wr_q, mem_wr_d;
   logic            abort_q, abort_d;
   logic            busy_q, busy_d;

   // Address-phase detection and decode terms
   logic addr_phase;
   logic cfg_cmd, cfg_hit;
   logic mem_cmd, mem_wr_cmd, mem_en, bar0_hit, bar1_hit, mem_hit;
   logic bus_idle;
   logic timeout;

   // A falling FRAME# edge is only meaningful when it was high on the previous clock;
   // after reset frame_prev_q is 0, so a transaction already in flight is never claimed.
   assign addr_phase = (state_q == ST_IDLE) && !PCI_FRAMEn_I && frame_prev_q;

   assign cfg_cmd = (PCI_CBEn_I == 4'b1010) || (PCI_CBEn_I == 4'b1011);
   assign cfg_hit = cfg_cmd && PCI_IDSEL_I && (PCI_AD_I[1:0] == 2'b00);

   assign mem_wr_cmd = (PCI_CBEn_I == 4'b0111) || (PCI_CBEn_I == 4'b1111);
   assign mem_cmd    = mem_wr_cmd || (PCI_CBEn_I == 4'b0110) ||
                       (PCI_CBEn_I == 4'b1100) || (PCI_CBEn_I == 4'b1110);
   assign mem_en     = CFG_REG_0x04_I[1];
   assign bar0_hit   = (PCI_AD_I[31:20] == CFG_REG_0x10_I[31:20]);
   assign bar1_hit   = (PCI_AD_I[31:20] == CFG_REG_0x11_I[31:20]);
   assign mem_hit    = mem_cmd && mem_en && (bar0_hit || bar1_hit);

   assign bus_idle = PCI_FRAMEn_I && PCI_IRDYn_I;
   assign timeout  = (cnt_q == CNT_LAST);

   // Register bits that carry no meaning for this block
   logic unused_cfg_bits;
   assign unused_cfg_bits = ^{CFG_REG_0x04_I[31:2], CFG_REG_0x04_I[0],
                              CFG_REG_0x10_I[19:0], CFG_REG_0x11_I[19:0]};

   // State, counter and registered outputs
   always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
      if (PHY_RST_I) begin
         state_q      <= ST_IDLE;
         frame_prev_q <= 1'b0;
         cnt_q        <= '0;
         add_q        <= '0;
         cfg_wr_q     <= 1'b0;
         add2cfg_q    <= 1'b0;
         mem_sel_q    <= 1'b0;
         mem_bar_q    <= 1'b0;
         mem_wr_q     <= 1'b0;
         abort_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_prev_q <= PCI_FRAMEn_I;
         cnt_q        <= cnt_d;
         add_q        <= add_d;
         cfg_wr_q     <= cfg_wr_d;
         add2cfg_q    <= add2cfg_d;
         mem_sel_q    <= mem_sel_d;
         mem_bar_q    <= mem_bar_d;
         mem_wr_q     <= mem_wr_d;
         abort_q      <= abort_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state and next-output logic; pulses default low, latched fields default to hold
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      add_d     = add_q;
      cfg_wr_d  = cfg_wr_q;
      mem_bar_d = mem_bar_q;
      mem_wr_d  = mem_wr_q;
      add2cfg_d = 1'b0;
      mem_sel_d = 1'b0;
      abort_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (addr_phase) begin
               add_d = PCI_AD_I[23:2];
               if (cfg_hit) begin
                  cfg_wr_d  = PCI_CBEn_I[0];
                  cnt_d     = '0;
                  add2cfg_d = 1'b1;
                  state_d   = ST_CFG;
               end else if (mem_hit) begin
                  // BAR0 takes priority when both windows match
                  mem_bar_d = !bar0_hit;
                  mem_wr_d  = mem_wr_cmd;
                  cnt_d     = '0;
                  mem_sel_d = 1'b1;
                  state_d   = ST_MEM;
               end else begin
                  state_d = ST_IGNORE;
               end
            end
         end

         ST_CFG: begin
            cnt_d = cnt_q + CNT_ONE;
            if (DEFSM_CFG_END_I) begin
               state_d = ST_TURN;
            end else if (timeout) begin
               abort_d = 1'b1;
               state_d = ST_TURN;
            end
         end

         ST_MEM: begin
            cnt_d     = cnt_q + CNT_ONE;
            mem_sel_d = 1'b1;
            if (DEFSM_MEM_END_I) begin
               mem_sel_d = 1'b0;
               state_d   = ST_TURN;
            end else if (timeout) begin
               mem_sel_d = 1'b0;
               abort_d   = 1'b1;
               state_d   = ST_TURN;
            end
         end

         ST_IGNORE: begin
            if (bus_idle) begin
               state_d = ST_IDLE;
            end
         end

         ST_TURN: begin
            if (bus_idle) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign PCI_ADD_O         = add_q;
   assign CFG_WR_O          = cfg_wr_q;
   assign DEFSM_ADD2CFG_O   = add2cfg_q;
   assign MEM_SEL_O         = mem_sel_q;
   assign MEM_BAR_O         = mem_bar_q;
   assign MEM_WR_O          = mem_wr_q;
   assign CFG_STATE_ABORT_O = abort_q;
   assign DEFSM_BUSY_O      = busy_q;
   assign DEFSM_STATE_O     = state_q;

endmodule

// File: doc/pci_target_dec_fsm.md
# pci_target_dec_fsm

PCI target address-phase decoder and transaction sequencer. It samples every PCI address phase and decodes it as a Type-0 configuration access, a memory access to one of two BARs, or no hit. It then hands the claimed transaction to the configuration manager or the memory back-end and waits for that back-end to finish, with a timeout abort if it never does. It sits between the PCI pad layer and the config/memory target FSMs, and is the only block that starts them.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles spent in CFG/MEM before abort (legal range 2..255)

Ports:
- PHY_CLK33_I  in  1  33 MHz PCI clock
- PHY_RST_I  in  1  reset, asynchronous, active-high
- PCI_FRAMEn_I  in  1  bus FRAME#
- PCI_IRDYn_I  in  1  bus IRDY#
- PCI_IDSEL_I  in  1  bus IDSEL
- PCI_AD_I  in  32  bus AD
- PCI_CBEn_I  in  4  bus C/BE# (command during the address phase)
- CFG_REG_0x04_I  in  32  command/status register; bit 1 is memory-space enable
- CFG_REG_0x10_I  in  32  BAR0; bits 31:20 are the 1 MB window base
- CFG_REG_0x11_I  in  32  BAR1; bits 31:20 are the 1 MB window base
- PCI_ADD_O  out  22  latched AD[23:2]
- CFG_WR_O  out  1  latched configuration direction, 1 = write
- DEFSM_ADD2CFG_O  out  1  one-cycle start pulse to the config manager
- DEFSM_CFG_END_I  in  1  config manager done
- MEM_SEL_O  out  1  memory back-end select, held high until done
- MEM_BAR_O  out  1  0 = BAR0 hit, 1 = BAR1 hit
- MEM_WR_O  out  1  latched memory direction, 1 = write
- DEFSM_MEM_END_I  in  1  memory back-end done
- CFG_STATE_ABORT_O  out  1  one-cycle pulse on timeout; feeds status bit 27
- DEFSM_BUSY_O  out  1  high in every state except IDLE
- DEFSM_STATE_O  out  3  state encoding (debug)

## Operation
- States and encodings: IDLE=0, CFG=1, MEM=2, IGNORE=3, TURN=4.
- Address phase: FRAMEn sampled 0 while the registered previous FRAMEn is 1, in IDLE only. Falling edges seen in any other state are ignored.
- On an address phase, latch AD[23:2], C/BE# and IDSEL, then decode:
  - Config hit:
    - C/BE# = 1010 (read) or 1011 (write).
    - IDSEL = 1 and AD[1:0] = 00.
    - Action: CFG_WR_O = C/BE#[0], go to CFG.
  - Memory hit:
    - C/BE# is one of 0110, 0111, 1100, 1110, 1111.
    - Memory-space enable is 1.
    - AD[31:20] equals BAR0[31:20] or BAR1[31:20]. If both match, BAR0 wins.
    - Action: set MEM_BAR_O to the matching BAR, set MEM_WR_O = 1 for 0111 and 1111 only, go to MEM.
  - Any other command, or no match: go to IGNORE. No output asserts.
- CFG:
  - DEFSM_ADD2CFG_O is high during the first cycle in CFG only.
  - Wait for DEFSM_CFG_END_I = 1, then go to TURN.
- MEM:
  - MEM_SEL_O is high for the whole stay in MEM.
  - Wait for DEFSM_MEM_END_I = 1, then go to TURN.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1). It clears to 0 on entry to CFG/MEM and increments every cycle in those states.
  - If the count equals TIMEOUT_CYCLES-1 and END is 0, pulse CFG_STATE_ABORT_O for one cycle and go to TURN.
  - If END and the timeout fall in the same cycle, END wins and there is no abort.
- IGNORE: stay until FRAMEn = 1 and IRDYn = 1 are sampled together, then go to IDLE.
- TURN: stay at least one cycle. Exit to IDLE when FRAMEn = 1 and IRDYn = 1.
- END inputs are ignored outside their own state.
- The latched address and direction hold their values until the next address phase.

## Timing
- All outputs are registered and change on the rising edge of PHY_CLK33_I.
- Reset, asserted asynchronously:
  - All outputs go to 0, the counter to 0, the state to IDLE.
  - The previous-FRAMEn register goes to 0, so no address phase is seen until FRAMEn has been sampled 1.
  - Reset mid-transaction therefore never claims the transaction already in flight.
- Address phase sampled at edge N: at edge N+1 the state is CFG with DEFSM_ADD2CFG_O = 1 (or MEM with MEM_SEL_O = 1). BUSY goes to 1 at N+1.
- END sampled 1 at edge M: at M+1 the state is TURN and MEM_SEL_O is 0. At M+2 the state is IDLE if the bus is idle.
- Back-to-back transactions: a new address phase is accepted no earlier than the first IDLE cycle.
- Timeout: when END never arrives, the abort pulse and the exit to TURN occur TIMEOUT_CYCLES edges after entry into CFG/MEM.

## Test plan
- Config read: IDSEL = 1, C/BE# = 1010, AD = 0x0000_0010 -> next cycle state 1, DEFSM_ADD2CFG_O high for 1 cycle, PCI_ADD_O = 0x000004, CFG_WR_O = 0. END after 3 cycles -> TURN, then IDLE.
- Memory write: BAR1 = 0x8010_0000, cmd reg = 0x2, C/BE# = 0111, AD = 0x8012_3450 -> MEM_SEL_O = 1, MEM_BAR_O = 1, MEM_WR_O = 1 until DEFSM_MEM_END_I.
- No hit: memory-space enable = 0, or AD outside both BARs, or C/BE# = 0010 -> IGNORE. DEFSM_ADD2CFG_O and MEM_SEL_O never assert; IDLE once FRAMEn = IRDYn = 1.
- Timeout: config hit with END held 0 -> CFG_STATE_ABORT_O is one cycle high exactly 16 edges after entering CFG, then TURN. END and timeout in the same cycle -> no abort.
- Reset: assert PHY_RST_I in MEM with FRAMEn held 0, release -> outputs 0 immediately and no claim. Next genuine FRAMEn 1->0 edge is claimed.
- Overlap: both BARs = 0x8000_0000 with a hit -> MEM_BAR_O = 0. FRAMEn edge during TURN -> ignored.
